// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter sharing the VGA adapter plot port between the paddle, ball and
// brick drawers, with a built-in full-screen clear to black.
module vga_draw_arbiter #(
    parameter int X_W       = 8,
    parameter int Y_W       = 8,
    parameter int COLOUR_W  = 3,
    parameter int MAX_BURST = 32,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic [2:0]            req,
    output logic [2:0]            gnt,
    input  logic [3*X_W-1:0]      in_x,
    input  logic [3*Y_W-1:0]      in_y,
    input  logic [3*COLOUR_W-1:0] in_colour,
    input  logic [2:0]            in_plot,
    input  logic [2:0]            in_last,
    input  logic                  clear_req,
    output logic                  clear_done,
    output logic [X_W-1:0]        vga_x,
    output logic [Y_W-1:0]        vga_y,
    output logic [COLOUR_W-1:0]   vga_colour,
    output logic                  vga_plot,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [1:0]          state;
    logic [1:0]          g;
    logic [1:0]          rr;
    logic [1:0]          pick;
    logic [BW-1:0]       beat;
    logic                clear_pending;
    logic                fin;
    logic [X_W-1:0]      cx;
    logic [Y_W-1:0]      cy;
    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [COLOUR_W-1:0] sel_colour;
    logic                sel_plot;
    logic                sel_last;
    logic                sel_req;
    logic                release_c;
    logic                found;
    logic [1:0]          idx;

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_plot   = 1'b0;
        sel_last   = 1'b0;
        sel_req    = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (g == 2'(i)) begin
                sel_x      = in_x[i*X_W +: X_W];
                sel_y      = in_y[i*Y_W +: Y_W];
                sel_colour = in_colour[i*COLOUR_W +: COLOUR_W];
                sel_plot   = in_plot[i];
                sel_last   = in_last[i];
                sel_req    = req[i];
            end
        end
    end

    // First requester at or above rr, wrapping 2 -> 0.
    always_comb begin
        pick  = rr;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            idx = 2'((32'(rr) + k) % 3);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign release_c = (sel_plot && sel_last) || !sel_req ||
                       (sel_plot && (beat == BW'(MAX_BURST - 1)));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            g             <= '0;
            rr            <= '0;
            beat          <= '0;
            clear_pending <= 1'b0;
            fin           <= 1'b0;
            cx            <= '0;
            cy            <= '0;
            gnt           <= '0;
            clear_done    <= 1'b0;
            vga_x         <= '0;
            vga_y         <= '0;
            vga_colour    <= '0;
            vga_plot      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            clear_done <= fin;
            fin        <= 1'b0;
            if (clear_req)
                clear_pending <= 1'b1;
            case (state)
                S_IDLE: begin
                    vga_plot <= 1'b0;
                    if (clear_pending) begin
                        state         <= S_CLEAR;
                        clear_pending <= clear_req;
                        cx            <= '0;
                        cy            <= '0;
                        busy          <= 1'b1;
                    end else if (|req) begin
                        state <= S_GRANT;
                        g     <= pick;
                        gnt   <= 3'b001 << pick;
                        beat  <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    vga_x      <= sel_x;
                    vga_y      <= sel_y;
                    vga_colour <= sel_colour;
                    vga_plot   <= sel_plot;
                    if (sel_plot)
                        beat <= beat + BW'(1);
                    if (release_c) begin
                        state <= S_IDLE;
                        gnt   <= '0;
                        rr    <= (g == 2'd2) ? 2'd0 : g + 2'd1;
                        busy  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    vga_x      <= cx;
                    vga_y      <= cy;
                    vga_colour <= '0;
                    vga_plot   <= 1'b1;
                    if (cx == X_W'(SCREEN_W - 1)) begin
                        cx <= '0;
                        if (cy == Y_W'(SCREEN_H - 1)) begin
                            // clear_done lands one cycle after the final pixel
                            cy    <= '0;
                            state <= S_IDLE;
                            fin   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            cy <= cy + Y_W'(1);
                        end
                    end else begin
                        cx <= cx + X_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    gnt      <= '0;
                    vga_plot <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Shares the single VGA adapter plot port between three pixel-drawing requesters: 0 = paddle, 1 = ball, 2 = brick field.
- Grants the port to one requester at a time using round-robin priority, and forwards that requester's pixel stream through a registered output stage.
- Also runs a built-in full-screen clear to black, used at game restart and after a loss.
- Sits between paddle_module / ball / brick drawers and vga_adapter.

Parameters:
X_W, 8, x coordinate width
Y_W, 8, y coordinate width
COLOUR_W, 3, colour width
MAX_BURST, 32, maximum plot beats per grant before forced release
SCREEN_W, 160, clear-scan width in pixels
SCREEN_H, 120, clear-scan height in pixels

Ports:
CLOCK_50  input  1  system clock
resetn  input  1  asynchronous active-low reset
req  input  3  per-requester draw request, level
gnt  output  3  one-hot grant; all zero when no requester owns the port
in_x  input  3*X_W  packed x; requester i in bits [i*X_W +: X_W]
in_y  input  3*Y_W  packed y
in_colour  input  3*COLOUR_W  packed colour
in_plot  input  3  per-requester pixel valid
in_last  input  3  marks the final pixel of a burst; qualified by in_plot
clear_req  input  1  single-cycle pulse requesting a screen clear
clear_done  output  1  one-cycle pulse when the clear finishes
vga_x  output  X_W  pixel x to adapter
vga_y  output  Y_W  pixel y to adapter
vga_colour  output  COLOUR_W  pixel colour to adapter
vga_plot  output  1  write enable to adapter
busy  output  1  high in GRANT or CLEAR

Behaviour:
- Decided: one clock (CLOCK_50); resetn is asynchronous and active-low.
- Reset values:
  - state IDLE; gnt = 0; all vga_* outputs = 0; clear_done = 0; busy = 0.
  - Round-robin pointer rr = 0; beat counter = 0; clear_pending = 0.
- States:
  - IDLE
  - GRANT: the granted index g is held in a register.
  - CLEAR: scan counters cx, cy.
- clear_req handling: a pulse sets clear_pending in any state. clear_pending is cleared on entry to CLEAR.
- IDLE transitions, evaluated each cycle:
  - If clear_pending, go to CLEAR. Clear has priority over all requesters.
  - Else if any req bit is set, pick the first set bit searching upward from rr, wrapping 2→0. Go to GRANT, set gnt one-hot next edge, reset beat counter.
  - Else stay in IDLE.
- GRANT:
  - Output stage: every cycle, vga_x/y/colour register the granted requester's fields, and vga_plot registers in_plot[g]. Latency is exactly 1 cycle from in_plot to vga_plot.
  - in_plot from non-granted requesters is ignored; their pixels are dropped.
  - Beat counter increments on each in_plot[g].
  - Release conditions (any one):
    - in_plot[g] and in_last[g] in the same cycle;
    - req[g] deasserted (abort);
    - beat counter reaching MAX_BURST with in_plot[g].
  - On release: the final pixel is still forwarded, gnt goes to 0 the next cycle, rr = (g+1) mod 3, state returns to IDLE.
  - Minimum gap between grants is one IDLE cycle.
- CLEAR:
  - gnt = 0.
  - Scans cx over 0..SCREEN_W-1 (inner loop) and cy over 0..SCREEN_H-1 (outer loop). One pixel per cycle with vga_plot = 1 and colour 0. Total SCREEN_W*SCREEN_H cycles, which is 19200 at defaults.
  - After pixel (SCREEN_W-1, SCREEN_H-1): clear_done pulses 1 cycle, vga_plot drops, state goes to IDLE.
  - clear_req arriving during CLEAR sets clear_pending, so a second full clear follows.
- A clear is never inserted mid-burst. It waits for the current grant to release.
- Outside GRANT and CLEAR: vga_plot = 0, and vga_x/y/colour hold their last values.
- Reset mid-operation: all state returns to the reset values immediately (asynchronously). The in-progress burst or clear is abandoned with no clear_done.
- busy = (state != IDLE), registered.

Test Plan:
- Reset, then req = 3'b111 held, each burst 4 pixels ending with last → grants in order 0, 1, 2, 0; vga_plot appears 1 cycle after each in_plot; one IDLE cycle between grants.
- Paddle granted; ball drives in_plot with x = 50 at the same time → vga_x never shows 50 and only paddle pixels appear.
- Ball granted, plots 32 pixels without in_last → gnt drops after the 32nd beat and rr = 2.
- clear_req pulse while paddle mid-burst → burst finishes, then 19200 consecutive vga_plot cycles with colour 0 ending at (159, 119), then a single clear_done pulse, then pending requests resume.
- resetn low during CLEAR at pixel (10, 5) → outputs 0 without waiting for a clock edge, no clear_done; after release the arbiter is in IDLE with rr = 0.
- Requester 2 drops req after 2 pixels without last → grant released next cycle and rr = 0.
